nibble_serial_subtractor: RTL and testbench

//   Multi-cycle subtractor: computes DIFF = A - B - BIN, 4 bits per clock, LSB nibble first.

---
 rtl/nibble_serial_subtractor_pkg.sv | 16 +
 rtl/nibble_serial_subtractor_borrow_lookahead_4.sv | 32 +++
 rtl/nibble_serial_subtractor.sv | 118 +++++++++++
 tb/tb_nibble_serial_subtractor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encodings
// and the nibble-counter width helper.
package nibble_serial_subtractor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Counter must be at least one bit wide even when there is a single nibble.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_borrow_lookahead_4.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bi with flattened
// generate/propagate borrow terms instead of a ripple chain.
module borrow_lookahead_4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_bi,
  output logic [3:0] o_d,
  output logic       o_bo,
  output logic       o_b3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:1] w_br;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  assign w_g = ~i_a & i_b;
  assign w_p = ~(i_a ^ i_b);

  assign w_br[1] = w_g[0] | (w_p[0] & i_bi);
  assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_bi);
  assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_bi);
  assign w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_bi);

  assign o_d  = i_a ^ i_b ^ {w_br[3:1], i_bi};
  assign o_bo = w_br[4];
  assign o_b3 = w_br[3];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: DIFF = A - B - BIN, one nibble per clock, LSB first,
// with valid/ready handshakes on both sides.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = cnt_width(NIBBLES);
  localparam int SLOTS   = 2 ** CW;
  localparam logic [CW-1:0] LAST_K = CW'(NIBBLES - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [3:0]       w_a_slot [SLOTS];
  logic [3:0]       w_b_slot [SLOTS];
  logic [3:0]       w_a_cur;
  logic [3:0]       w_b_cur;
  logic [3:0]       w_d;
  logic             w_bo;
  logic             w_b3;
  logic [WIDTH-1:0] w_diff_next;

  // Slot table padded to a power of two so r_k can index it at full width.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < NIBBLES) begin : g_real
      assign w_a_slot[gi] = r_a[4*gi +: 4];
      assign w_b_slot[gi] = r_b[4*gi +: 4];
    end else begin : g_pad
      assign w_a_slot[gi] = 4'h0;
      assign w_b_slot[gi] = 4'h0;
    end
  end

  assign w_a_cur = w_a_slot[r_k];
  assign w_b_cur = w_b_slot[r_k];

  borrow_lookahead_4 u_bla (
    .i_a  (w_a_cur),
    .i_b  (w_b_cur),
    .i_bi (r_br),
    .o_d  (w_d),
    .o_bo (w_bo),
    .o_b3 (w_b3)
  );

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_diff
    assign w_diff_next[4*gi +: 4] = (r_k == CW'(gi)) ? w_d : r_diff[4*gi +: 4];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_k     <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_br    <= i_bin;
            r_k     <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_diff <= w_diff_next;
          r_br   <= w_bo;
          if (r_k == LAST_K) begin
            r_state <= ST_DONE;
            r_bout  <= w_bo;
            r_ovf   <= w_b3 ^ w_bo;
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        ST_DONE: begin
          if (i_out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_diff      = r_diff;
  assign o_bout      = r_bout;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: directed 16-bit vectors plus an
// exhaustive 4-bit sweep, both checked against an arithmetic reference.
module tb_nibble_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, bin;
  logic [15:0] a, b;
  logic        in_ready, out_valid, bout, ovf;
  logic [15:0] diff;

  logic        v4_in_valid, v4_out_ready, v4_bin;
  logic [3:0]  v4_a, v4_b;
  logic        v4_in_ready, v4_out_valid, v4_bout, v4_ovf;
  logic [3:0]  v4_diff;

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] q16[$];
  logic [17:0] q4[$];

  nibble_serial_subtractor #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_bin(bin), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_diff(diff), .o_bout(bout), .o_ovf(ovf)
  );

  nibble_serial_subtractor #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v4_in_valid), .o_in_ready(v4_in_ready),
    .i_a(v4_a), .i_b(v4_b), .i_bin(v4_bin), .o_out_valid(v4_out_valid),
    .i_out_ready(v4_out_ready), .o_diff(v4_diff), .o_bout(v4_bout), .o_ovf(v4_ovf)
  );

  // Reference: {ovf, bout, diff} from plain integer arithmetic at width w.
  function automatic logic [17:0] ref_sub(input int w, input logic [15:0] ra, rb, input logic rbin);
    longint m, half, ua, ub, r, sa, sb, sr;
    logic [17:0] res;
    m    = longint'(1) << w;
    half = m >> 1;
    ua   = longint'(ra);
    ub   = longint'(rb);
    r    = ua - ub - longint'(rbin);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    sr   = sa - sb - longint'(rbin);
    res[15:0] = 16'((r + m) % m);
    res[16]   = (r < 0);
    res[17]   = (sr < -half) || (sr > half - 1);
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Per-cycle compare against the model queue whenever a result is presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
    end else begin
      if (out_valid) begin
        if (q16.size() == 0) begin
          chk("w16_spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("w16_diff", 32'(diff), 32'(q16[0][15:0]));
          chk("w16_bout", 32'(bout), 32'(q16[0][16]));
          chk("w16_ovf", 32'(ovf), 32'(q16[0][17]));
          chk("w16_in_ready_while_valid", 32'(in_ready), 32'd0);
          if (out_ready) void'(q16.pop_front());
        end
      end
      if (in_valid && in_ready) q16.push_back(ref_sub(16, a, b, bin));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
    end else begin
      if (v4_out_valid) begin
        if (q4.size() == 0) begin
          chk("w4_spurious_out_valid", 32'(v4_out_valid), 32'd0);
        end else begin
          chk("w4_diff", 32'(v4_diff), 32'(q4[0][3:0]));
          chk("w4_bout", 32'(v4_bout), 32'(q4[0][16]));
          chk("w4_ovf", 32'(v4_ovf), 32'(q4[0][17]));
          if (v4_out_ready) void'(q4.pop_front());
        end
      end
      if (v4_in_valid && v4_in_ready) q4.push_back(ref_sub(4, {12'h0, v4_a}, {12'h0, v4_b}, v4_bin));
    end
  end

  task automatic do_op16(input logic [15:0] ta, tb, input logic tbin,
                         input logic [15:0] ed, input logic eb, eo, input int hold);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w16_latency", 32'(n), 32'd4);
    if (out_valid) begin
      @(negedge clk);
      chk("w16_lit_diff", 32'(diff), 32'(ed));
      chk("w16_lit_bout", 32'(bout), 32'(eb));
      chk("w16_lit_ovf", 32'(ovf), 32'(eo));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        in_valid = (i == 2);
        a = 16'hFFFF; b = 16'h0000;
        @(negedge clk);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_diff", 32'(diff), 32'(ed));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_diff_held", 32'(diff), 32'(ed));
    end
  endtask

  task automatic do_op4(input logic [3:0] ta, tb, input logic tbin);
    int n;
    @(posedge clk); #1;
    v4_a = ta; v4_b = tb; v4_bin = tbin; v4_in_valid = 1'b1;
    @(posedge clk); #1;
    v4_in_valid = 1'b0;
    n = 0;
    while (!v4_out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4_latency", 32'(n), 32'd1);
    v4_out_ready = 1'b1;
    @(posedge clk); #1;
    v4_out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; bin = 1'b0; a = '0; b = '0;
    v4_in_valid = 1'b0; v4_out_ready = 1'b0; v4_bin = 1'b0; v4_a = '0; v4_b = '0;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst4_in_ready", 32'(v4_in_ready), 32'd1);
    chk("rst4_out_valid", 32'(v4_out_valid), 32'd0);

    // Hand-computed values pin the reference model itself.
    chk("model_1234", 32'(ref_sub(16, 16'h1234, 16'h0234, 1'b0)), 32'h0_1000);
    chk("model_zero_bin", 32'(ref_sub(16, 16'h0000, 16'h0000, 1'b1)), 32'h1_FFFF);
    chk("model_8000", 32'(ref_sub(16, 16'h8000, 16'h0001, 1'b0)), 32'h2_7FFF);
    chk("model_7fff", 32'(ref_sub(16, 16'h7FFF, 16'hFFFF, 1'b0)), 32'h3_8000);
    chk("model_w4_8m1", 32'(ref_sub(4, 16'h0008, 16'h0001, 1'b0)), 32'h2_0007);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
    do_op16(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
    do_op16(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 0);
    do_op16(16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 5);

    // Abort an operation after two nibbles have been written.
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_bout", 32'(bout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_valid", 32'(out_valid), 32'd0);
    do_op16(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          do_op4(4'(ia), 4'(ib), 1'(ic));

    repeat (3) @(negedge clk);
    chk("w4_queue_drained", 32'(q4.size()), 32'd0);
    chk("w16_queue_drained", 32'(q16.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
